tqv_periph_initiator: RTL

Bus initiator for the TinyQV peripheral interface. It drives address, data_in, data_write_n and data_read_n into a peripheral, the same signals the TinyQV core drives. It takes one transaction at a time from a valid/ready command port and returns read data or an error on a valid/ready response port. It sits in front of peripherals such as the xoshiro PRNG, for standalone bring-up, DMA-style feeders and bus-level verification. It also latches the peripheral's user_interrupt.

---
 rtl/tqv_bus_pkg.sv | 32 +++
 rtl/tqv_irq_edge_latch.sv | 30 +++
 rtl/tqv_periph_initiator.sv | 122 ++++++++++++
 3 files changed

// File: rtl/tqv_bus_pkg.sv
// Shared TinyQV peripheral bus definitions.
// Strobe/size codes, initiator states, read-data masking.
package tqv_bus_pkg;

  localparam logic [1:0] SZ_8    = 2'b00;
  localparam logic [1:0] SZ_16   = 2'b01;
  localparam logic [1:0] SZ_32   = 2'b10;
  localparam logic [1:0] SZ_IDLE = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RESP
  } state_t;

  // Zero-extend peripheral read data to the access size.
  function automatic logic [31:0] mask_rdata(
    input logic [1:0]  size,
    input logic [31:0] data
  );
    logic [31:0] m;
    unique case (size)
      SZ_8:    m = {24'd0, data[7:0]};
      SZ_16:   m = {16'd0, data[15:0]};
      SZ_32:   m = data;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tqv_irq_edge_latch.sv
// Rising-edge detector with a sticky pending flag.
// A new edge beats a simultaneous clear.
module tqv_irq_edge_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_in,
  input  logic irq_clear,
  output logic irq_pending
);

  logic prev;
  logic rise;

  assign rise = irq_in & ~prev;

  // Track previous level and hold the pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev        <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      prev <= irq_in;
      if (rise)
        irq_pending <= 1'b1;
      else if (irq_clear)
        irq_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/tqv_periph_initiator.sv
// TinyQV peripheral bus initiator.
// One command at a time, registered bus strobes.
module tqv_periph_initiator
  import tqv_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [5:0]  address,
  output logic [31:0] data_in,
  output logic [1:0]  data_write_n,
  output logic [1:0]  data_read_n,
  input  logic [31:0] data_out,
  input  logic        data_ready,
  input  logic        user_interrupt,
  output logic        irq_pending,
  input  logic        irq_clear
);

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  state_t     state;
  logic [1:0] size_q;
  logic [7:0] tmo_cnt;
  logic [7:0] tmo_nxt;

  assign cmd_ready = (state == IDLE);
  assign tmo_nxt   = tmo_cnt + 8'd1;

  // Transaction sequencer with registered bus and response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      size_q       <= SZ_8;
      tmo_cnt      <= '0;
      address      <= '0;
      data_in      <= '0;
      data_write_n <= SZ_IDLE;
      data_read_n  <= SZ_IDLE;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            tmo_cnt <= '0;
            if (cmd_size == SZ_IDLE) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              address <= cmd_addr;
              data_in <= cmd_wdata;
              size_q  <= cmd_size;
              if (cmd_write) begin
                state        <= WRITE;
                data_write_n <= cmd_size;
              end else begin
                state       <= READ;
                data_read_n <= cmd_size;
              end
            end
          end
        end
        WRITE: begin
          data_write_n <= SZ_IDLE;
          state        <= RESP;
          rsp_valid    <= 1'b1;
          rsp_err      <= 1'b0;
          rsp_rdata    <= '0;
        end
        READ: begin
          if (data_ready) begin
            data_read_n <= SZ_IDLE;
            state       <= RESP;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b0;
            rsp_rdata   <= mask_rdata(size_q, data_out);
          end else if (tmo_nxt == TMO) begin
            tmo_cnt     <= tmo_nxt;
            data_read_n <= SZ_IDLE;
            state       <= RESP;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_rdata   <= '0;
          end else begin
            tmo_cnt <= tmo_nxt;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  tqv_irq_edge_latch u_irq (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq_in      (user_interrupt),
    .irq_clear   (irq_clear),
    .irq_pending (irq_pending)
  );

endmodule
